// File: rtl/rail_shutdown_seq_pkg.sv
// Shared definitions for the rail power sequencers: FSM encoding, default
// timing constants and the counter-width helper used by rail_timer users.
package rail_shutdown_seq_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DROP  = 2'd1,
      ST_DWELL = 2'd2,
      ST_OFF   = 2'd3
   } state_e;

   localparam int DEFAULT_DWELL_CYCLES   = 16384;
   localparam int DEFAULT_TIMEOUT_CYCLES = 65536;

   // One shared counter must hold the larger of the two intervals minus one.
   function automatic int cnt_width(int dwell, int timeout);
      int m;
      m = (dwell > timeout) ? dwell : timeout;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/rail_shutdown_seq_if.sv
// Board-side bundle between up-sequencer/PG sensing and the shutdown sequencer.
// No handshake: all inputs are levels, all outputs are registered levels.
interface rail_shutdown_seq_if #(
   parameter int NSTAGES = 4
);
   localparam int IW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

   logic               UP_DONE;
   logic               SHUTDOWN_REQ;
   logic [NSTAGES-1:0] STAGE_PG;
   logic [NSTAGES-1:0] STAGE_ALLOW;
   logic               BUSY;
   logic               OFF;
   logic               FAULT;
   logic [IW-1:0]      FAULT_STAGE;

   modport master (
      output UP_DONE, SHUTDOWN_REQ, STAGE_PG,
      input  STAGE_ALLOW, BUSY, OFF, FAULT, FAULT_STAGE
   );

   modport slave (
      input  UP_DONE, SHUTDOWN_REQ, STAGE_PG,
      output STAGE_ALLOW, BUSY, OFF, FAULT, FAULT_STAGE
   );
endinterface

// File: rtl/rail_shutdown_seq_timer.sv
// rail_timer: loadable down-counter that saturates at zero; done_o flags zero.
// Loading N-1 on entry makes done_o true in the N-th cycle of the interval.
module rail_timer #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   output logic          done_o
);
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);
endmodule

// File: rtl/rail_shutdown_seq.sv
// Reverse-order power-down sequencer: withdraws stage permits from the top
// stage down to stage 0 on a request or on PG loss, with timeout and dwell.
module rail_shutdown_seq
   import rail_shutdown_seq_pkg::*;
#(
   parameter int                 NSTAGES        = 4,
   parameter logic [NSTAGES-1:0] PG_MASK        = 4'b1110,
   parameter int                 DWELL_CYCLES   = DEFAULT_DWELL_CYCLES,
   parameter int                 TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                clk,
   input  logic                rst_n,
   rail_shutdown_seq_if.slave  bus,
   output state_e              dbg_state_o
);
   localparam int IW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
   localparam int CW = cnt_width(DWELL_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0] DW_LOAD = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES - 1);

   state_e             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [NSTAGES-1:0] allow_q, allow_d;
   logic               busy_q, busy_d;
   logic               off_q, off_d;
   logic               fault_q, fault_d;
   logic [IW-1:0]      fstage_q, fstage_d;

   logic               tmr_load;
   logic [CW-1:0]      tmr_val;
   logic               tmr_done;
   logic [NSTAGES-1:0] pg_fail;
   logic [IW-1:0]      pg_low_idx;

   rail_timer #(.CW(CW)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   // PG is only meaningful once the up-sequencer has finished.
   assign pg_fail = bus.UP_DONE ? (PG_MASK & ~bus.STAGE_PG) : '0;

   always_comb begin
      pg_low_idx = '0;
      for (int i = NSTAGES - 1; i >= 0; i--) begin
         if (pg_fail[i]) pg_low_idx = IW'(i);
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      allow_d  = allow_q;
      busy_d   = busy_q;
      off_d    = off_q;
      fault_d  = fault_q;
      fstage_d = fstage_q;
      tmr_load = 1'b0;
      tmr_val  = TO_LOAD;
      unique case (state_q)
         ST_RUN: begin
            if (bus.SHUTDOWN_REQ || (pg_fail != '0)) begin
               if (pg_fail != '0 && !fault_q) begin
                  fault_d  = 1'b1;
                  fstage_d = pg_low_idx;
               end
               idx_d              = IW'(NSTAGES - 1);
               allow_d[NSTAGES-1] = 1'b0;
               busy_d             = 1'b1;
               tmr_load           = 1'b1;
               tmr_val            = TO_LOAD;
               state_d            = ST_DROP;
            end
         end
         ST_DROP: begin
            if (!PG_MASK[idx_q] || !bus.STAGE_PG[idx_q]) begin
               tmr_load = 1'b1;
               tmr_val  = DW_LOAD;
               state_d  = ST_DWELL;
            end else if (tmr_done) begin
               if (!fault_q) begin
                  fault_d  = 1'b1;
                  fstage_d = idx_q;
               end
               tmr_load = 1'b1;
               tmr_val  = DW_LOAD;
               state_d  = ST_DWELL;
            end
         end
         ST_DWELL: begin
            if (tmr_done) begin
               if (idx_q == '0) begin
                  busy_d  = 1'b0;
                  off_d   = 1'b1;
                  state_d = ST_OFF;
               end else begin
                  idx_d                   = idx_q - IW'(1);
                  allow_d[idx_q - IW'(1)] = 1'b0;
                  tmr_load                = 1'b1;
                  tmr_val                 = TO_LOAD;
                  state_d                 = ST_DROP;
               end
            end
         end
         ST_OFF: begin
            allow_d = '0;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         idx_q    <= '0;
         allow_q  <= '1;
         busy_q   <= 1'b0;
         off_q    <= 1'b0;
         fault_q  <= 1'b0;
         fstage_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         allow_q  <= allow_d;
         busy_q   <= busy_d;
         off_q    <= off_d;
         fault_q  <= fault_d;
         fstage_q <= fstage_d;
      end
   end

   assign bus.STAGE_ALLOW = allow_q;
   assign bus.BUSY        = busy_q;
   assign bus.OFF         = off_q;
   assign bus.FAULT       = fault_q;
   assign bus.FAULT_STAGE = fstage_q;
   assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_rail_shutdown_seq.sv
// Directed bench for rail_shutdown_seq with DWELL=4, TIMEOUT=8 and a rail
// model whose PG follows its permit two cycles late.
module tb_rail_shutdown_seq;
   import rail_shutdown_seq_pkg::*;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_e dbg_state;

   logic [3:0] pg_d1 = 4'hF;
   logic [3:0] pg_d2 = 4'hF;
   logic [3:0] force_hi = 4'h0;
   logic [3:0] force_lo = 4'h0;

   int n_checks = 0;
   int n_errors = 0;

   rail_shutdown_seq_if #(.NSTAGES(4)) bus ();

   rail_shutdown_seq #(
      .NSTAGES        (4),
      .PG_MASK        (4'b1110),
      .DWELL_CYCLES   (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Rail model: PG lags the permit by two clocks, with per-stage overrides.
   always @(posedge clk) begin
      if (!rst_n) begin
         pg_d1 <= 4'hF;
         pg_d2 <= 4'hF;
      end else begin
         pg_d1 <= bus.STAGE_ALLOW;
         pg_d2 <= pg_d1;
      end
   end
   assign bus.STAGE_PG = (pg_d2 | force_hi) & ~force_lo;

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      bus.UP_DONE      = 1'b0;
      bus.SHUTDOWN_REQ = 1'b0;
      force_hi         = 4'h0;
      force_lo         = 4'h0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic pulse_req();
      bus.SHUTDOWN_REQ = 1'b1;
      step(1);
      bus.SHUTDOWN_REQ = 1'b0;
   endtask

   // Permit held at prev for spacing-1 cycles, then becomes next.
   task automatic expect_drop(input string tag, input logic [3:0] prev,
                              input logic [3:0] next, input int spacing);
      step(spacing - 1);
      check_eq({tag, "_hold"}, 32'(bus.STAGE_ALLOW), 32'(prev));
      step(1);
      check_eq({tag, "_clear"}, 32'(bus.STAGE_ALLOW), 32'(next));
   endtask

   task automatic expect_off(input string tag);
      step(4);
      check_eq({tag, "_off_early"}, 32'(bus.OFF), 32'd0);
      step(1);
      check_eq({tag, "_off"}, 32'(bus.OFF), 32'd1);
      check_eq({tag, "_busy_end"}, 32'(bus.BUSY), 32'd0);
   endtask

   // ---------------- stimulus + checks ----------------
   initial begin
      do_reset();
      check_eq("rst_allow", 32'(bus.STAGE_ALLOW), 32'hF);
      check_eq("rst_busy", 32'(bus.BUSY), 32'd0);
      check_eq("rst_off", 32'(bus.OFF), 32'd0);
      check_eq("rst_fault", 32'(bus.FAULT), 32'd0);
      check_eq("rst_fstage", 32'(bus.FAULT_STAGE), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'(ST_RUN));

      // Orderly shutdown.
      pulse_req();
      check_eq("ord_trig_allow", 32'(bus.STAGE_ALLOW), 32'h7);
      check_eq("ord_trig_busy", 32'(bus.BUSY), 32'd1);
      expect_drop("ord_s3", 4'h7, 4'h3, 7);
      expect_drop("ord_s2", 4'h3, 4'h1, 7);
      expect_drop("ord_s1", 4'h1, 4'h0, 7);
      expect_off("ord");
      check_eq("ord_fault", 32'(bus.FAULT), 32'd0);
      bus.SHUTDOWN_REQ = 1'b1;
      step(3);
      check_eq("ord_off_hold_allow", 32'(bus.STAGE_ALLOW), 32'h0);
      check_eq("ord_off_hold", 32'(bus.OFF), 32'd1);

      // PG loss on stage 2 while running.
      do_reset();
      bus.UP_DONE = 1'b1;
      force_lo    = 4'b0100;
      step(1);
      check_eq("pgl_allow", 32'(bus.STAGE_ALLOW), 32'h7);
      check_eq("pgl_fault", 32'(bus.FAULT), 32'd1);
      check_eq("pgl_fstage", 32'(bus.FAULT_STAGE), 32'd2);
      expect_drop("pgl_s3", 4'h7, 4'h3, 7);
      expect_drop("pgl_s2", 4'h3, 4'h1, 5);
      expect_drop("pgl_s1", 4'h1, 4'h0, 7);
      expect_off("pgl");

      // Stage 3 PG stuck high: timeout after 8 cycles.
      do_reset();
      force_hi = 4'b1000;
      pulse_req();
      step(7);
      check_eq("stk_fault_pre", 32'(bus.FAULT), 32'd0);
      step(1);
      check_eq("stk_fault", 32'(bus.FAULT), 32'd1);
      check_eq("stk_fstage", 32'(bus.FAULT_STAGE), 32'd3);
      expect_drop("stk_s3", 4'h7, 4'h3, 4);
      expect_drop("stk_s2", 4'h3, 4'h1, 7);
      expect_drop("stk_s1", 4'h1, 4'h0, 7);
      expect_off("stk");

      // Request and stage-1 PG loss together, then a stage-3 timeout.
      do_reset();
      force_hi         = 4'b1000;
      force_lo         = 4'b0010;
      bus.UP_DONE      = 1'b1;
      bus.SHUTDOWN_REQ = 1'b1;
      step(1);
      bus.SHUTDOWN_REQ = 1'b0;
      check_eq("sim_fault", 32'(bus.FAULT), 32'd1);
      check_eq("sim_fstage", 32'(bus.FAULT_STAGE), 32'd1);
      expect_drop("sim_s3", 4'h7, 4'h3, 12);
      check_eq("sim_fstage_kept", 32'(bus.FAULT_STAGE), 32'd1);
      expect_drop("sim_s2", 4'h3, 4'h1, 7);
      expect_drop("sim_s1", 4'h1, 4'h0, 5);
      expect_off("sim");
      check_eq("sim_fstage_end", 32'(bus.FAULT_STAGE), 32'd1);

      // Reset during the dwell after stage 2, then restart.
      do_reset();
      pulse_req();
      expect_drop("mid_s3", 4'h7, 4'h3, 7);
      step(4);
      check_eq("mid_state", 32'(dbg_state), 32'(ST_DWELL));
      rst_n = 1'b0;
      step(1);
      check_eq("mid_rst_allow", 32'(bus.STAGE_ALLOW), 32'hF);
      check_eq("mid_rst_busy", 32'(bus.BUSY), 32'd0);
      rst_n = 1'b1;
      step(2);
      pulse_req();
      check_eq("mid_re_allow", 32'(bus.STAGE_ALLOW), 32'h7);
      check_eq("mid_re_busy", 32'(bus.BUSY), 32'd1);
      expect_drop("mid_re_s3", 4'h7, 4'h3, 7);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
